charbuf_cmd_scheduler: RTL and testbench
========================================

// Module: charbuf_cmd_scheduler
// PURPOSE
//  Front end for the 80x32 character buffer write port. Accepts terminal commands
//  (write char, clear screen, erase-to-EOL, fill test pattern) over a valid/ready handshake.
//  Writes single characters directly; sequences the buffer-init engine for bulk operations.
//  Muxes both sources onto the single RAM write port. Sits between the escape/cursor logic
//  and the char-buffer RAM.
// PARAMETERS
//  START_TIMEOUT  8   cycles after LAUNCH to wait for init_wr_en to rise before err abort
//  MAXCOL_M_1     79  last valid column index
// PORTS
//  clk            in   1   clock
//  resetn         in   1   reset, synchronous, active-low
//  cmd_valid      in   1   command present
//  cmd_ready      out  1   scheduler can accept (high only in IDLE)
//  cmd_op         in   2   00 write char, 01 clear screen, 10 erase-to-EOL, 11 fill pattern
//  cmd_row        in   5   target row (write char, erase-to-EOL)
//  cmd_col        in   7   target column (write char, erase-to-EOL)
//  cmd_data       in   7   character code (write char)
//  init_enable    out  1   to init engine; the engine starts on the falling edge
//  init_zeroize   out  1   to init engine; write zeros instead of pattern
//  init_part_line out  1   to init engine; partial-line erase
//  init_part_row  out  5   to init engine; row for partial-line erase
//  init_part_col  out  7   to init engine; start column for partial-line erase
//  init_wr_en     in   1   from init engine; write strobe
//  init_addr      in   12  from init engine; address {col,row}
//  init_data      in   7   from init engine; write data
//  ram_we         out  1   char-buffer write enable
//  ram_addr       out  12  char-buffer address {col[6:0],row[4:0]}
//  ram_wdata      out  7   char-buffer write data
//  busy           out  1   high in any state other than IDLE
//  done           out  1   1-cycle pulse when a command completes
//  err            out  1   1-cycle pulse, coincident with done, on a rejected or aborted command
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1; state IDLE; latched command fields 0.
//    The init engine shares resetn, so reset mid-operation silently abandons it.
//  States: IDLE, WRCHR, ARM, LAUNCH, RUN, DONE. Handshake: accept when cmd_valid & cmd_ready.
//  Accept with cmd_col>MAXCOL_M_1 and op 00 or 10 -> DONE with err=1. No RAM write occurs.
//  Op 00: IDLE->WRCHR. In WRCHR: ram_we=1, ram_addr={col,row}, ram_wdata=data.
//    WRCHR->DONE; done is asserted 2 cycles after accept.
//  Ops 01/10/11: IDLE->ARM->LAUNCH->RUN.
//    ARM: init_enable=1.
//    LAUNCH: init_enable=0. This gives the engine its falling edge.
//    init_zeroize=1 in ARM for op 01 and op 10; 0 for op 11.
//    Op 10: init_part_line=1 with part_row/part_col held through both ARM and LAUNCH. The engine
//      reloads its cursor only while it is idle and part_line is asserted, and zeroes it otherwise.
//  RUN: ram_we/addr/wdata = init_wr_en/init_addr/init_data, combinational passthrough.
//    Leave RUN on the first cycle with init_wr_en=0 after it was seen 1 -> DONE.
//    If init_wr_en stays 0 for START_TIMEOUT cycles after LAUNCH -> DONE with err=1.
//  Outside WRCHR and RUN: ram_we=0, ram_addr=0, ram_wdata=0.
//  DONE: done=1 for 1 cycle, then IDLE. cmd_ready=0 in DONE, so one cycle is lost between
//    back-to-back commands.
//  Expected write counts:
//    full clear: 2560, ending at addr 12'd2559 (col 79, row 31)
//    erase-to-EOL: 80-col, row constant
//    fill: data 0,1,..,127,0 wraps mod 128
//  cmd_* fields are sampled only at accept; later changes are ignored.
// TESTING
//  Op00 row3 col10 data 0x41 -> exactly one ram_we, addr {7'd10,5'd3}, wdata 0x41;
//    done 2 cycles after accept.
//  Op01 -> 2560 consecutive ram_we, all wdata 0, last addr 2559; then done=1, err=0, busy falls.
//  Op10 row5 col70 -> 10 writes, cols 70..79, row 5, data 0; done; no write outside row 5.
//  Op11 -> 2560 writes, wdata increments mod 128 starting at 0; done.
//  Op00 or op10 with col=80 -> done+err in the same cycle, zero ram_we;
//    then cmd_ready back to 1 next cycle.
//  resetn low mid-RUN of op01 -> next cycle: ram_we=0, busy=0, cmd_ready=1;
//    a new op00 completes normally.

Source files
------------

// File: rtl/charbuf_cmd_scheduler.sv
// Command front end for the 80x32 character buffer: writes single characters directly and
// sequences the init engine for clear / erase-to-EOL / fill, muxing both onto one RAM port.
module charbuf_cmd_scheduler #(
    parameter int START_TIMEOUT = 8,
    parameter int MAXCOL_M_1    = 79
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [1:0]  i_cmd_op,
    input  logic [4:0]  i_cmd_row,
    input  logic [6:0]  i_cmd_col,
    input  logic [6:0]  i_cmd_data,
    output logic        o_init_enable,
    output logic        o_init_zeroize,
    output logic        o_init_part_line,
    output logic [4:0]  o_init_part_row,
    output logic [6:0]  o_init_part_col,
    input  logic        i_init_wr_en,
    input  logic [11:0] i_init_addr,
    input  logic [6:0]  i_init_data,
    output logic        o_ram_we,
    output logic [11:0] o_ram_addr,
    output logic [6:0]  o_ram_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam logic [1:0] OP_WRCHR = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;
    localparam logic [1:0] OP_EOL   = 2'b10;
    localparam logic [1:0] OP_FILL  = 2'b11;
    localparam int         TW       = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRCHR,
        S_ARM,
        S_LAUNCH,
        S_RUN,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_op;
    logic [4:0]  r_row;
    logic [6:0]  r_col;
    logic [6:0]  r_data;
    logic        r_err;
    logic        r_seen;
    logic [TW-1:0] r_timer;
    logic        w_err_next;
    logic        w_seen_next;
    logic [TW-1:0] w_timer_next;
    logic        w_accept;
    logic        w_col_bad;

    assign w_accept  = i_cmd_valid && (r_state == S_IDLE);
    assign w_col_bad = (i_cmd_col > 7'(MAXCOL_M_1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_op    <= 2'b00;
            r_row   <= 5'd0;
            r_col   <= 7'd0;
            r_data  <= 7'd0;
            r_err   <= 1'b0;
            r_seen  <= 1'b0;
            r_timer <= '0;
        end else begin
            r_state <= w_next;
            r_err   <= w_err_next;
            r_seen  <= w_seen_next;
            r_timer <= w_timer_next;
            if (w_accept) begin
                r_op   <= i_cmd_op;
                r_row  <= i_cmd_row;
                r_col  <= i_cmd_col;
                r_data <= i_cmd_data;
            end
        end
    end

    // Config lines stay stable through ARM and LAUNCH so the engine sees them on its start edge.
    always_comb begin
        w_next           = r_state;
        w_err_next       = r_err;
        w_seen_next      = r_seen;
        w_timer_next     = r_timer;
        o_cmd_ready      = 1'b0;
        o_busy           = 1'b1;
        o_done           = 1'b0;
        o_err            = 1'b0;
        o_init_enable    = 1'b0;
        o_init_zeroize   = 1'b0;
        o_init_part_line = 1'b0;
        o_init_part_row  = 5'd0;
        o_init_part_col  = 7'd0;
        o_ram_we         = 1'b0;
        o_ram_addr       = 12'd0;
        o_ram_wdata      = 7'd0;

        case (r_state)
            S_IDLE: begin
                o_cmd_ready = 1'b1;
                o_busy      = 1'b0;
                if (w_accept) begin
                    w_err_next = 1'b0;
                    if (((i_cmd_op == OP_WRCHR) || (i_cmd_op == OP_EOL)) && w_col_bad) begin
                        w_next     = S_DONE;
                        w_err_next = 1'b1;
                    end else if (i_cmd_op == OP_WRCHR) begin
                        w_next = S_WRCHR;
                    end else begin
                        w_next = S_ARM;
                    end
                end
            end
            S_WRCHR: begin
                o_ram_we    = 1'b1;
                o_ram_addr  = {r_col, r_row};
                o_ram_wdata = r_data;
                w_next      = S_DONE;
            end
            S_ARM, S_LAUNCH: begin
                o_init_enable    = (r_state == S_ARM);
                o_init_zeroize   = (r_op == OP_CLEAR) || (r_op == OP_EOL);
                o_init_part_line = (r_op == OP_EOL);
                if (r_op == OP_EOL) begin
                    o_init_part_row = r_row;
                    o_init_part_col = r_col;
                end
                if (r_state == S_ARM) begin
                    w_next = S_LAUNCH;
                end else begin
                    w_next       = S_RUN;
                    w_seen_next  = 1'b0;
                    w_timer_next = '0;
                end
            end
            S_RUN: begin
                o_ram_we    = i_init_wr_en;
                o_ram_addr  = i_init_addr;
                o_ram_wdata = i_init_data;
                // The engine never started if no strobe arrives inside the timeout window.
                if (i_init_wr_en) begin
                    w_seen_next = 1'b1;
                end else if (r_seen) begin
                    w_next = S_DONE;
                end else if (r_timer == TW'(START_TIMEOUT - 1)) begin
                    w_next     = S_DONE;
                    w_err_next = 1'b1;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            S_DONE: begin
                o_done = 1'b1;
                o_err  = r_err;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_charbuf_cmd_scheduler.sv
// Directed bench for charbuf_cmd_scheduler with a small behavioural init engine and a write
// monitor that compares every RAM write against the expected address/data sequence.
module tb_charbuf_cmd_scheduler;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmdValid;
    logic        cmdReady;
    logic [1:0]  cmdOp;
    logic [4:0]  cmdRow;
    logic [6:0]  cmdCol;
    logic [6:0]  cmdData;
    logic        initEnable;
    logic        initZeroize;
    logic        initPartLine;
    logic [4:0]  initPartRow;
    logic [6:0]  initPartCol;
    logic        engWrEn;
    logic [11:0] engAddr;
    logic [6:0]  engData;
    logic        ramWe;
    logic [11:0] ramAddr;
    logic [6:0]  ramWdata;
    logic        busy;
    logic        done;
    logic        err;

    int checkCount = 0;
    int passCount  = 0;

    charbuf_cmd_scheduler dut (
        .clk              (clk),
        .resetn           (resetn),
        .i_cmd_valid      (cmdValid),
        .o_cmd_ready      (cmdReady),
        .i_cmd_op         (cmdOp),
        .i_cmd_row        (cmdRow),
        .i_cmd_col        (cmdCol),
        .i_cmd_data       (cmdData),
        .o_init_enable    (initEnable),
        .o_init_zeroize   (initZeroize),
        .o_init_part_line (initPartLine),
        .o_init_part_row  (initPartRow),
        .o_init_part_col  (initPartCol),
        .i_init_wr_en     (engWrEn),
        .i_init_addr      (engAddr),
        .i_init_data      (engData),
        .o_ram_we         (ramWe),
        .o_ram_addr       (ramAddr),
        .o_ram_wdata      (ramWdata),
        .o_busy           (busy),
        .o_done           (done),
        .o_err            (err)
    );

    always #5 clk = ~clk;

    // Behavioural init engine: starts on the falling edge of enable, streams one write per cycle.
    logic        engMute = 1'b0;
    logic        engActive;
    logic        engPrevEn;
    logic        engZero;
    logic        engPart;
    logic [4:0]  engRow;
    logic [6:0]  engCol;
    logic [11:0] engIdx;

    always @(posedge clk) begin
        if (!resetn) begin
            engActive <= 1'b0;
            engPrevEn <= 1'b0;
            engZero   <= 1'b0;
            engPart   <= 1'b0;
            engRow    <= 5'd0;
            engCol    <= 7'd0;
            engIdx    <= 12'd0;
            engWrEn   <= 1'b0;
            engAddr   <= 12'd0;
            engData   <= 7'd0;
        end else begin
            engPrevEn <= initEnable;
            if (engActive) begin
                engWrEn <= 1'b1;
                engData <= engZero ? 7'd0 : engIdx[6:0];
                engIdx  <= engIdx + 12'd1;
                if (engPart) begin
                    engAddr <= {engCol, engRow};
                    engCol  <= engCol + 7'd1;
                    if (engCol == 7'd79) engActive <= 1'b0;
                end else begin
                    engAddr <= engIdx;
                    if (engIdx == 12'd2559) engActive <= 1'b0;
                end
            end else begin
                engWrEn <= 1'b0;
                if (engPrevEn && !initEnable && !engMute) begin
                    engActive <= 1'b1;
                    engZero   <= initZeroize;
                    engPart   <= initPartLine;
                    engRow    <= initPartRow;
                    engCol    <= initPartCol;
                    engIdx    <= 12'd0;
                end
            end
        end
    end

    // Write monitor: expected address/data come from the mode the stimulus announces.
    int          expMode = 0;
    logic [11:0] expWAddr = 12'd0;
    logic [6:0]  expWData = 7'd0;
    logic [4:0]  expRow = 5'd0;
    logic [6:0]  expCol0 = 7'd0;
    int          wrBase = 0;
    int          wrCount = 0;
    int          badWr = 0;
    logic [11:0] lastAddr = 12'd0;

    function automatic logic [11:0] modelAddr(input int idx);
        case (expMode)
            0:       return expWAddr;
            2:       return {expCol0 + 7'(idx), expRow};
            default: return 12'(idx);
        endcase
    endfunction

    function automatic logic [6:0] modelData(input int idx);
        case (expMode)
            0:       return expWData;
            3:       return 7'(idx % 128);
            default: return 7'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (ramWe) begin
            if (ramAddr != modelAddr(wrCount - wrBase) || ramWdata != modelData(wrCount - wrBase))
                badWr <= badWr + 1;
            wrCount  <= wrCount + 1;
            lastAddr <= ramAddr;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    task automatic setExpect(input int mode, input logic [11:0] wAddr, input logic [6:0] wData,
                             input logic [4:0] row, input logic [6:0] col0);
        @(posedge clk);
        #1;
        expMode  = mode;
        expWAddr = wAddr;
        expWData = wData;
        expRow   = row;
        expCol0  = col0;
        wrBase   = wrCount;
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [4:0] row, input logic [6:0] col,
                                 input logic [6:0] data);
        int waitCyc = 0;
        @(negedge clk);
        while (!cmdReady && waitCyc < 20) begin
            @(negedge clk);
            waitCyc++;
        end
        checkOutput("cmd_ready before accept", 32'(cmdReady), 32'd1);
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdRow   = row;
        cmdCol   = col;
        cmdData  = data;
        @(posedge clk);
        #1;
        cmdValid = 1'b0;
        cmdOp    = ~op;
        cmdRow   = ~row;
        cmdCol   = ~col;
        cmdData  = ~data;
    endtask

    task automatic waitDone(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!done && cycles < budget);
        checkOutput("done within budget", 32'(done), 32'd1);
    endtask

    task automatic checkIdleAfter(input string tag);
        @(negedge clk);
        checkOutput({tag, " ready after done"}, 32'(cmdReady), 32'd1);
        checkOutput({tag, " busy after done"}, 32'(busy), 32'd0);
        checkOutput({tag, " done pulse width"}, 32'(done), 32'd0);
    endtask

    int cyc;

    initial begin
        resetn   = 1'b0;
        cmdValid = 1'b0;
        cmdOp    = 2'b00;
        cmdRow   = 5'd0;
        cmdCol   = 7'd0;
        cmdData  = 7'd0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("reset cmd_ready", 32'(cmdReady), 32'd1);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset err", 32'(err), 32'd0);
        checkOutput("reset ram_we", 32'(ramWe), 32'd0);
        checkOutput("reset ram_addr", 32'(ramAddr), 32'd0);
        checkOutput("reset init_enable", 32'(initEnable), 32'd0);

        // Single character write
        setExpect(0, {7'd10, 5'd3}, 7'h41, 5'd0, 7'd0);
        applyStimulus(2'b00, 5'd3, 7'd10, 7'h41);
        waitDone(10, cyc);
        checkOutput("wrchr done latency", 32'(cyc), 32'd2);
        checkOutput("wrchr err", 32'(err), 32'd0);
        checkOutput("wrchr write count", 32'(wrCount - wrBase), 32'd1);
        checkOutput("wrchr bad writes", 32'(badWr), 32'd0);
        checkIdleAfter("wrchr");

        // Full clear
        setExpect(1, 12'd0, 7'd0, 5'd0, 7'd0);
        applyStimulus(2'b01, 5'd0, 7'd0, 7'd0);
        waitDone(3000, cyc);
        checkOutput("clear done latency", 32'(cyc), 32'd2565);
        checkOutput("clear err", 32'(err), 32'd0);
        checkOutput("clear write count", 32'(wrCount - wrBase), 32'd2560);
        checkOutput("clear last addr", 32'(lastAddr), 32'd2559);
        checkOutput("clear bad writes", 32'(badWr), 32'd0);
        checkIdleAfter("clear");

        // Erase to end of line from row 5 col 70
        setExpect(2, 12'd0, 7'd0, 5'd5, 7'd70);
        applyStimulus(2'b10, 5'd5, 7'd70, 7'd0);
        @(negedge clk);
        checkOutput("eol arm enable", 32'(initEnable), 32'd1);
        checkOutput("eol arm zeroize", 32'(initZeroize), 32'd1);
        checkOutput("eol arm part_line", 32'(initPartLine), 32'd1);
        checkOutput("eol arm part_row", 32'(initPartRow), 32'd5);
        checkOutput("eol arm part_col", 32'(initPartCol), 32'd70);
        @(negedge clk);
        checkOutput("eol launch enable", 32'(initEnable), 32'd0);
        checkOutput("eol launch part_line", 32'(initPartLine), 32'd1);
        checkOutput("eol launch part_col", 32'(initPartCol), 32'd70);
        waitDone(100, cyc);
        checkOutput("eol done latency", 32'(cyc), 32'd13);
        checkOutput("eol err", 32'(err), 32'd0);
        checkOutput("eol write count", 32'(wrCount - wrBase), 32'd10);
        checkOutput("eol last addr", 32'(lastAddr), 32'({7'd79, 5'd5}));
        checkOutput("eol bad writes", 32'(badWr), 32'd0);
        checkIdleAfter("eol");

        // Fill pattern
        setExpect(3, 12'd0, 7'd0, 5'd0, 7'd0);
        applyStimulus(2'b11, 5'd0, 7'd0, 7'd0);
        @(negedge clk);
        checkOutput("fill arm zeroize", 32'(initZeroize), 32'd0);
        checkOutput("fill arm part_line", 32'(initPartLine), 32'd0);
        waitDone(3000, cyc);
        checkOutput("fill err", 32'(err), 32'd0);
        checkOutput("fill write count", 32'(wrCount - wrBase), 32'd2560);
        checkOutput("fill last addr", 32'(lastAddr), 32'd2559);
        checkOutput("fill bad writes", 32'(badWr), 32'd0);
        checkIdleAfter("fill");

        // Column out of range for op00 and op10
        setExpect(0, 12'd0, 7'd0, 5'd0, 7'd0);
        applyStimulus(2'b00, 5'd2, 7'd80, 7'h55);
        waitDone(10, cyc);
        checkOutput("wrchr col80 latency", 32'(cyc), 32'd1);
        checkOutput("wrchr col80 err", 32'(err), 32'd1);
        checkOutput("wrchr col80 writes", 32'(wrCount - wrBase), 32'd0);
        checkIdleAfter("wrchr col80");
        applyStimulus(2'b10, 5'd2, 7'd80, 7'd0);
        waitDone(10, cyc);
        checkOutput("eol col80 latency", 32'(cyc), 32'd1);
        checkOutput("eol col80 err", 32'(err), 32'd1);
        checkOutput("eol col80 writes", 32'(wrCount - wrBase), 32'd0);
        checkOutput("eol col80 no arm", 32'(initEnable), 32'd0);
        checkIdleAfter("eol col80");

        // Engine never starts -> start timeout abort
        engMute = 1'b1;
        setExpect(3, 12'd0, 7'd0, 5'd0, 7'd0);
        applyStimulus(2'b11, 5'd0, 7'd0, 7'd0);
        waitDone(50, cyc);
        checkOutput("timeout latency", 32'(cyc), 32'd11);
        checkOutput("timeout err", 32'(err), 32'd1);
        checkOutput("timeout writes", 32'(wrCount - wrBase), 32'd0);
        checkIdleAfter("timeout");
        engMute = 1'b0;

        // Reset in the middle of a full clear, then a normal write at the last column
        setExpect(1, 12'd0, 7'd0, 5'd0, 7'd0);
        applyStimulus(2'b01, 5'd0, 7'd0, 7'd0);
        repeat (100) @(negedge clk);
        checkOutput("midrun ram_we", 32'(ramWe), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        checkOutput("midreset ram_we", 32'(ramWe), 32'd0);
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset cmd_ready", 32'(cmdReady), 32'd1);
        resetn = 1'b1;
        setExpect(0, {7'd79, 5'd31}, 7'h7F, 5'd0, 7'd0);
        applyStimulus(2'b00, 5'd31, 7'd79, 7'h7F);
        waitDone(10, cyc);
        checkOutput("post-reset wrchr latency", 32'(cyc), 32'd2);
        checkOutput("post-reset wrchr err", 32'(err), 32'd0);
        checkOutput("post-reset wrchr writes", 32'(wrCount - wrBase), 32'd1);
        checkOutput("post-reset bad writes", 32'(badWr), 32'd0);
        checkIdleAfter("post-reset");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
